// File: rtl/mlp_dnd_engine_if.sv
// Patch-in / score-out handshake bundle for the MLP denoiser core.
// master: upstream patch source + downstream result sink; slave: the engine.
// in_*: valid/ready patch channel; out_*: valid/ready result channel.
interface mlp_dnd_engine_if #(
  parameter int NPIX  = 49,
  parameter int MAG_W = 4,
  parameter int ACC_W = 16
);
  logic                          in_valid;
  logic                          in_ready;
  logic [NPIX-1:0][MAG_W-1:0]    in_mag;
  logic [NPIX-1:0][1:0]          in_pol;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [ACC_W-1:0]       out_score;
  logic                          out_signal;

  modport master (
    output in_valid, in_mag, in_pol, out_ready,
    input  in_ready, out_valid, out_score, out_signal
  );

  modport slave (
    input  in_valid, in_mag, in_pol, out_ready,
    output in_ready, out_valid, out_score, out_signal
  );
endinterface

// File: rtl/mlp_dnd_engine.sv
// Sequential two-layer MLP scoring one event patch (signal vs noise).
// Latency: result registered NPIX+N2+1 edges after accept (60 at defaults).
// Backpressure: one patch in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk, rst_n (sync, active low); bus = patch/result handshake (slave);
//   weights_n1_mag/pol, weights_n2 = static weight LUT inputs; busy = not IDLE.
module mlp_dnd_engine #(
  parameter int NPIX      = 49,
  parameter int N2        = 10,
  parameter int MAG_W     = 4,
  parameter int ACC_W     = 16,
  parameter int HID_W     = 8,
  parameter int HID_SHIFT = 4,
  parameter int THRESH    = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  mlp_dnd_engine_if.slave               bus,
  input  logic [N2-1:0][NPIX:0][5:0]    weights_n1_mag,
  input  logic [N2-1:0][NPIX:0][5:0]    weights_n1_pol,
  input  logic [N2:0][3:0]              weights_n2,
  output logic                          busy
);
  // idx walks pixels in L1 and hidden neurons (plus one finalize slot) in L2
  localparam int MAXN = (NPIX > N2 + 1) ? NPIX : N2 + 1;
  localparam int IW   = (MAXN > 1) ? $clog2(MAXN) : 1;
  localparam logic signed [ACC_W-1:0] HID_MAX = ACC_W'((1 << HID_W) - 1);
  localparam logic signed [ACC_W-1:0] THR     = ACC_W'(THRESH);

  typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;
  state_t state, state_nx;

  logic [IW-1:0]              idx;
  logic [NPIX-1:0][MAG_W-1:0] mag_q;
  logic [NPIX-1:0][1:0]       pol_q;
  logic signed [ACC_W-1:0]    acc1 [N2];
  logic signed [ACC_W-1:0]    acc2;

  logic accept, l1_last, l2_last;
  assign bus.in_ready = rst_n && (state == IDLE);
  assign busy         = (state != IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign l1_last      = (idx == IW'(NPIX - 1));
  assign l2_last      = (idx == IW'(N2));

  // bias slot of the polarity table has no meaning; keep it visibly unused
  logic [N2-1:0][5:0] unused_pol_bias;
  always_comb begin
    for (int h = 0; h < N2; h++) unused_pol_bias[h] = weights_n1_pol[h][0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = L1;
      L1:      if (l1_last)      state_nx = L2;
      L2:      if (l2_last)      state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Layer 1: select current pixel and its weight column, N2 parallel MACs
  logic [MAG_W-1:0]        cur_mag;
  logic [1:0]              cur_pol;
  logic signed [ACC_W-1:0] mag_x;
  logic signed [5:0]       wm_cur [N2];
  logic signed [5:0]       wp_cur [N2];
  logic signed [ACC_W-1:0] inc1 [N2];
  logic signed [ACC_W-1:0] wm_x, wp_x;

  always_comb begin
    cur_mag = '0;
    cur_pol = '0;
    wm_x    = '0;
    wp_x    = '0;
    for (int h = 0; h < N2; h++) begin
      wm_cur[h] = '0;
      wp_cur[h] = '0;
      inc1[h]   = '0;
    end
    for (int p = 0; p < NPIX; p++) begin
      if (idx == IW'(p)) begin
        cur_mag = mag_q[p];
        cur_pol = pol_q[p];
        for (int h = 0; h < N2; h++) begin
          wm_cur[h] = weights_n1_mag[h][p+1];
          wp_cur[h] = weights_n1_pol[h][p+1];
        end
      end
    end
    mag_x = {{(ACC_W-MAG_W){1'b0}}, cur_mag};
    for (int h = 0; h < N2; h++) begin
      wm_x = {{(ACC_W-6){wm_cur[h][5]}}, wm_cur[h]};
      wp_x = {{(ACC_W-6){wp_cur[h][5]}}, wp_cur[h]};
      inc1[h] = mag_x * wm_x;
      // 01 = +1, 11 = -1, 00/10 contribute nothing
      if (cur_pol == 2'b01)      inc1[h] = inc1[h] + wp_x;
      else if (cur_pol == 2'b11) inc1[h] = inc1[h] - wp_x;
    end
  end

  // Layer 2: ReLU, shift, saturate hidden j then one MAC
  logic signed [ACC_W-1:0] acc_sel, relu, shifted, hid_x, w2_x, inc2;
  logic [3:0]              w2_sel;
  logic [HID_W-1:0]        hid;

  always_comb begin
    acc_sel = '0;
    w2_sel  = '0;
    for (int h = 0; h < N2; h++) begin
      if (idx == IW'(h)) begin
        acc_sel = acc1[h];
        w2_sel  = weights_n2[h+1];
      end
    end
    relu    = acc_sel[ACC_W-1] ? '0 : acc_sel;
    shifted = relu >>> HID_SHIFT;
    hid     = (shifted > HID_MAX) ? {HID_W{1'b1}} : shifted[HID_W-1:0];
    hid_x   = {{(ACC_W-HID_W){1'b0}}, hid};
    w2_x    = {{(ACC_W-4){w2_sel[3]}}, w2_sel};
    inc2    = hid_x * w2_x;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx            <= '0;
      mag_q          <= '0;
      pol_q          <= '0;
      acc2           <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_score  <= '0;
      bus.out_signal <= 1'b0;
      for (int h = 0; h < N2; h++) acc1[h] <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mag_q <= bus.in_mag;
          pol_q <= bus.in_pol;
          idx   <= '0;
          acc2  <= {{(ACC_W-4){weights_n2[0][3]}}, weights_n2[0]};
          for (int h = 0; h < N2; h++)
            acc1[h] <= {{(ACC_W-6){weights_n1_mag[h][0][5]}}, weights_n1_mag[h][0]};
        end
        L1: begin
          for (int h = 0; h < N2; h++) acc1[h] <= acc1[h] + inc1[h];
          idx <= l1_last ? '0 : idx + IW'(1);
        end
        L2: begin
          // extra slot at idx == N2 publishes the finished sum
          if (l2_last) begin
            bus.out_score  <= acc2;
            bus.out_signal <= (acc2 > THR);
            bus.out_valid  <= 1'b1;
            idx            <= '0;
          end else begin
            acc2 <= acc2 + inc2;
            idx  <= idx + IW'(1);
          end
        end
        DONE: if (bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_dnd_engine.sv
// Directed bench: two engines (HID_SHIFT 0 and 4) share stimulus and weights;
// vector table checks scores/flags/latency, then backpressure and mid-L1 reset.
module tb_mlp_dnd_engine;
  localparam int NPIX = 49, N2 = 10, MAG_W = 4, ACC_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                       in_valid = 1'b0;
  logic                       out_ready = 1'b0;
  logic [NPIX-1:0][MAG_W-1:0] mag;
  logic [NPIX-1:0][1:0]       pol;
  logic [N2-1:0][NPIX:0][5:0] w1m, w1p;
  logic [N2:0][3:0]           w2;
  logic                       busy0, busy4;

  mlp_dnd_engine_if #(.NPIX(NPIX), .MAG_W(MAG_W), .ACC_W(ACC_W)) b0 ();
  mlp_dnd_engine_if #(.NPIX(NPIX), .MAG_W(MAG_W), .ACC_W(ACC_W)) b4 ();

  assign b0.in_valid = in_valid;  assign b4.in_valid = in_valid;
  assign b0.out_ready = out_ready; assign b4.out_ready = out_ready;
  assign b0.in_mag = mag;         assign b4.in_mag = mag;
  assign b0.in_pol = pol;         assign b4.in_pol = pol;

  mlp_dnd_engine #(.NPIX(NPIX), .N2(N2), .MAG_W(MAG_W), .ACC_W(ACC_W), .HID_W(8),
                   .HID_SHIFT(0), .THRESH(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .weights_n1_mag(w1m),
    .weights_n1_pol(w1p), .weights_n2(w2), .busy(busy0));

  mlp_dnd_engine #(.NPIX(NPIX), .N2(N2), .MAG_W(MAG_W), .ACC_W(ACC_W), .HID_W(8),
                   .HID_SHIFT(4), .THRESH(0)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(b4), .weights_n1_mag(w1m),
    .weights_n1_pol(w1p), .weights_n2(w2), .busy(busy4));

  typedef struct {
    string nm;
    int b1, wm_all, wm0, wp_idx, wp_val, w20, w2h;
    int mag_all, mag0, pol_all, pol_idx, pol_code;
    int e0, e4;
  } vec_t;

  vec_t vt [8];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_cfg(input vec_t v);
    for (int h = 0; h < N2; h++) begin
      for (int i = 0; i <= NPIX; i++) begin
        w1m[h][i] = (i == 0) ? 6'(v.b1) : ((i == 1) ? 6'(v.wm0) : 6'(v.wm_all));
        w1p[h][i] = (i == v.wp_idx) ? 6'(v.wp_val) : 6'd0;
      end
      w2[h+1] = 4'(v.w2h);
    end
    w2[0] = 4'(v.w20);
    for (int p = 0; p < NPIX; p++) begin
      mag[p] = (p == 0) ? 4'(v.mag0) : 4'(v.mag_all);
      pol[p] = (p == v.pol_idx) ? 2'(v.pol_code) : 2'(v.pol_all);
    end
  endtask

  // Called at the negedge right after the accept edge; measures edges to out_valid.
  task automatic wait_out(input string nm, input int e0, input int e4);
    int lat = 0;
    while (!b0.out_valid && lat < 200) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, lat, 60);
    chk({nm, " vld4"}, b4.out_valid, 1);
    chk({nm, " score0"}, $signed(b0.out_score), e0);
    chk({nm, " sig0"}, b0.out_signal, (e0 > 0) ? 1 : 0);
    chk({nm, " score4"}, $signed(b4.out_score), e4);
    chk({nm, " sig4"}, b4.out_signal, (e4 > 0) ? 1 : 0);
  endtask

  task automatic release_out(input string nm);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({nm, " vld drop"}, b0.out_valid | b4.out_valid, 0);
    chk({nm, " rdy back"}, b0.in_ready & b4.in_ready, 1);
  endtask

  task automatic run_vec(input string nm, input int e0, input int e4);
    @(negedge clk);
    chk({nm, " rdy"}, b0.in_ready & b4.in_ready, 1);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk({nm, " busy"}, busy0 & busy4, 1);
    chk({nm, " rdy low"}, b0.in_ready | b4.in_ready, 0);
    wait_out(nm, e0, e4);
    release_out(nm);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        nm        b1  wmA wm0 wpI wpV w20 w2h mA  m0  pA pI pC   e0      e4
    vt[0] = '{"bias",    8,  0,  0,  1,  0, -3,  1,  7,  7, 1, 0, 1,     77,     -3};
    vt[1] = '{"relu",   -8,  0,  0,  1,  0, -3,  1,  9,  3, 3, 0, 1,     -3,     -3};
    vt[2] = '{"sat",    31, 31, 31,  1,  0,  0,  1, 15, 15, 0, 0, 0,   2550,   2550};
    vt[3] = '{"satneg", 31, 31, 31,  1,  0,  0, -8, 15, 15, 0, 0, 0, -20400, -20400};
    vt[4] = '{"polneg",  0,  0,  0,  6, -4,  0,  2,  0,  0, 0, 5, 3,     80,      0};
    vt[5] = '{"pol10",   0,  0,  0,  6, -4,  0,  2,  0,  0, 0, 5, 2,      0,      0};
    vt[6] = '{"magsign",31,  0, -1,  1,  0, -8,  7,  0, 15, 0, 0, 0,   1112,     62};
    vt[7] = '{"polpos",  0,  0,  0,  2,  5,  0,  1,  0,  0, 0, 1, 1,     50,      0};

    // reset state
    set_cfg(vt[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst vld", b0.out_valid | b4.out_valid, 0);
    chk("rst score", $signed(b0.out_score) | $signed(b4.out_score), 0);
    chk("rst sig", b0.out_signal | b4.out_signal, 0);
    chk("rst busy", busy0 | busy4, 0);
    chk("rst rdy", b0.in_ready | b4.in_ready, 0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("post rst rdy", b0.in_ready & b4.in_ready, 1);

    for (int k = 0; k < 8; k++) begin
      set_cfg(vt[k]);
      run_vec(vt[k].nm, vt[k].e0, vt[k].e4);
    end

    // backpressure with a second patch held upstream
    set_cfg(vt[0]);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("bp rdy low", b0.in_ready, 0);
    wait_out("bp1", 77, -3);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); @(negedge clk);
      chk("bp hold vld", b0.out_valid & b4.out_valid, 1);
      chk("bp hold score", $signed(b0.out_score), 77);
      chk("bp hold sig", b0.out_signal, 1);
      chk("bp hold rdy", b0.in_ready | b4.in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk("bp rdy rise", b0.in_ready & b4.in_ready, 1);
    chk("bp vld drop", b0.out_valid | b4.out_valid, 0);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    chk("bp second busy", busy0 & busy4, 1);
    wait_out("bp2", 77, -3);
    release_out("bp2");

    // reset at edge T+25 of layer 1
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (24) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      chk("mrst busy", busy0 | busy4, 0);
      chk("mrst rdy", b0.in_ready | b4.in_ready, 0);
      chk("mrst vld", b0.out_valid | b4.out_valid, 0);
    end
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 70; c++) begin
        @(posedge clk); @(negedge clk);
        if (b0.out_valid || b4.out_valid) seen++;
      end
      chk("mrst no result", seen, 0);
    end
    run_vec("after rst", 77, -3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
